// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit stream multiplexer with per-channel
// valid/ready, a registered output stage, and either fixed-select or
// round-robin arbitration.
// Optional packet lock: define STREAM_MUX_LAST_LOCK_EN to add in_last/out_last
// and hold the grant on one channel until its last beat transfers.
module stream_mux_rr #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_ch
`ifdef STREAM_MUX_LAST_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last
`endif
);

  localparam int unsigned LAST_CH = NUM_CH - 1;

  logic             load_en_c;
  logic             grant_vld_c;
  logic [SEL_W-1:0] grant_ch_c;
  logic             xfer_c;
  logic [WIDTH-1:0] grant_data_c;
  logic             ptr_adv_c;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_next_c;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;
  logic             grant_last_c;
`endif

  // Output register can take a beat when empty or being drained this cycle
  assign load_en_c = !out_valid || out_ready;

  // Grant selection: fixed select, round-robin scan from ptr, or packet lock
  always_comb begin
    logic             hi_vld;
    logic             lo_vld;
    logic [SEL_W-1:0] hi_ch;
    logic [SEL_W-1:0] lo_ch;
    grant_vld_c = 1'b0;
    grant_ch_c  = '0;
    hi_vld      = 1'b0;
    lo_vld      = 1'b0;
    hi_ch       = '0;
    lo_ch       = '0;
    if (!mode) begin
      // Out-of-range sel matches no channel, so it never grants
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (32'(sel) == c && in_valid[c]) begin
          grant_vld_c = 1'b1;
          grant_ch_c  = SEL_W'(c);
        end
      end
    end else begin
      // First valid at or above ptr wins; otherwise wrap to first valid below
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (in_valid[c] && c >= 32'(ptr_q) && !hi_vld) begin
          hi_vld = 1'b1;
          hi_ch  = SEL_W'(c);
        end
        if (in_valid[c] && c < 32'(ptr_q) && !lo_vld) begin
          lo_vld = 1'b1;
          lo_ch  = SEL_W'(c);
        end
      end
      grant_vld_c = hi_vld || lo_vld;
      grant_ch_c  = hi_vld ? hi_ch : lo_ch;
    end
`ifdef STREAM_MUX_LAST_LOCK_EN
    // A packet in flight overrides mode, sel and other requesters
    if (lock_q) begin
      grant_vld_c = 1'b0;
      grant_ch_c  = lock_ch_q;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (32'(lock_ch_q) == c && in_valid[c]) begin
          grant_vld_c = 1'b1;
        end
      end
    end
`endif
  end

  // One-hot ready towards the granted producer, forced low during reset
  always_comb begin
    in_ready = '0;
    if (!reset && grant_vld_c && load_en_c) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (32'(grant_ch_c) == c) begin
          in_ready[c] = 1'b1;
        end
      end
    end
  end

  assign xfer_c = |(in_ready & in_valid);

  // Data (and last flag) of the granted channel
  always_comb begin
    grant_data_c = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    grant_last_c = 1'b0;
`endif
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (32'(grant_ch_c) == c) begin
        grant_data_c = in_data[c*WIDTH +: WIDTH];
`ifdef STREAM_MUX_LAST_LOCK_EN
        grant_last_c = in_last[c];
`endif
      end
    end
  end

  // Round-robin pointer moves past the winner; with packet lock only on the last beat
  always_comb begin
`ifdef STREAM_MUX_LAST_LOCK_EN
    ptr_adv_c = mode && xfer_c && grant_last_c;
`else
    ptr_adv_c = mode && xfer_c;
`endif
    ptr_next_c = (32'(grant_ch_c) == LAST_CH) ? '0 : SEL_W'(grant_ch_c + 1'b1);
  end

  // Round-robin pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (ptr_adv_c) begin
      ptr_q <= ptr_next_c;
    end
  end

  // Output stage: load on transfer, empty when drained with nothing new
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (xfer_c) begin
      out_valid <= 1'b1;
      out_data  <= grant_data_c;
      out_ch    <= grant_ch_c;
`ifdef STREAM_MUX_LAST_LOCK_EN
      out_last  <= grant_last_c;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  // Packet lock: set by a non-last beat, released by the last beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer_c) begin
      lock_q    <= !grant_last_c;
      lock_ch_q <= grant_ch_c;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (4-channel default plus a 5-channel
// instance for out-of-range select). Packet-lock steps are built when
// STREAM_MUX_LAST_LOCK_EN is defined.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5;
  logic [4:0]  in_ready5;
  logic [2:0]  sel5;
  logic [7:0]  out_data5;
  logic        out_valid5;
  logic [2:0]  out_ch5;

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
  logic [4:0]  in_last5;
  logic        out_last5;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.NUM_CH(4), .WIDTH(8), .SEL_W(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef STREAM_MUX_LAST_LOCK_EN
    ,
    .in_last   (in_last),
    .out_last  (out_last)
`endif
  );

  stream_mux_rr #(.NUM_CH(5), .WIDTH(8), .SEL_W(3)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .mode      (1'b0),
    .sel       (sel5),
    .out_data  (out_data5),
    .out_valid (out_valid5),
    .out_ready (1'b1),
    .out_ch    (out_ch5)
`ifdef STREAM_MUX_LAST_LOCK_EN
    ,
    .in_last   (in_last5),
    .out_last  (out_last5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp [6];
    rr_exp = '{0, 1, 2, 3, 0, 1};

    reset     = 1'b1;
    in_data   = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data5  = {8'h5C, 8'h33, 8'h03, 8'h02, 8'h01};
    in_valid5 = 5'b11111;
    sel5      = 3'd0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    in_last   = 4'b0000;
    in_last5  = 5'b00000;
`endif

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed mode, sel=2
    sel = 2'd2;
    #1;
    check("fix_in_ready", 32'(in_ready), 32'b0100);
    step();
    check("fix_out_data", 32'(out_data), 32'hA5);
    check("fix_out_ch", 32'(out_ch), 32'd2);
    check("fix_out_valid", 32'(out_valid), 32'd1);

    // Fixed mode, selected channel not valid: no grant, output drains and holds
    sel      = 2'd1;
    in_valid = 4'b1101;
    #1;
    check("fix_nogrant_ready", 32'(in_ready), 32'd0);
    step();
    check("fix_drain_valid", 32'(out_valid), 32'd0);
    check("fix_drain_data", 32'(out_data), 32'hA5);
    check("fix_drain_ch", 32'(out_ch), 32'd2);

    // Five-channel instance: sel out of range never grants, sel=4 does
    sel5 = 3'd5;
    #1;
    check("sel5_oor_ready", 32'(in_ready5), 32'd0);
    sel5 = 3'd4;
    #1;
    check("sel4_ready", 32'(in_ready5), 32'b10000);
    step();
    check("sel4_out_data", 32'(out_data5), 32'h5C);
    check("sel4_out_ch", 32'(out_ch5), 32'd4);
    sel5 = 3'd5;
    step();
    check("sel5_oor_drain", 32'(out_valid5), 32'd0);

    // Round-robin, all channels valid continuously
    mode     = 1'b1;
    sel      = 2'd0;
    in_valid = 4'b1111;
    #1;
    check("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("rr_seq_ch%0d", k), 32'(out_ch), 32'(rr_exp[k]));
      check($sformatf("rr_seq_data%0d", k), 32'(out_data), 32'(in_data[rr_exp[k]*8 +: 8]));
    end

    // Round-robin, only ch3 and ch1 valid, ptr now 2
    in_valid = 4'b1010;
    #1;
    check("rr_sparse_ready", 32'(in_ready), 32'b1000);
    step();
    check("rr_sparse_ch0", 32'(out_ch), 32'd3);
    step();
    check("rr_sparse_ch1", 32'(out_ch), 32'd1);
    step();
    check("rr_sparse_ch2", 32'(out_ch), 32'd3);
    check("rr_sparse_data", 32'(out_data), 32'h44);

    // Backpressure: output held, no ready, for 3 cycles
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd0);
      step();
      check($sformatf("bp_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_ch%0d", k), 32'(out_ch), 32'd3);
      check($sformatf("bp_data%0d", k), 32'(out_data), 32'h44);
    end
    // Release: new beat accepted the same cycle, no bubble
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0001);
    step();
    check("bp_release_ch", 32'(out_ch), 32'd0);
    check("bp_release_data", 32'(out_data), 32'h11);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while clk is high and a beat is held
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    step();
    check("prerst_valid", 32'(out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_clk_high", 32'(clk), 32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    check("midrst_ch", 32'(out_ch), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
`ifdef STREAM_MUX_LAST_LOCK_EN
    check("midrst_last", 32'(out_last), 32'd0);
`endif
    @(negedge clk);
    reset    = 1'b0;
    // Pointer was 1 before reset; reset returns it to 0
    mode     = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("postrst_ptr_ready", 32'(in_ready), 32'b0001);

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Packet lock: ch1 sends 3 beats while ch0 stays valid
    mode     = 1'b0;
    sel      = 2'd1;
    in_valid = 4'b0011;
    in_last  = 4'b0000;
    step();
    check("lock_b1_ch", 32'(out_ch), 32'd1);
    check("lock_b1_last", 32'(out_last), 32'd0);
    mode = 1'b1;
    sel  = 2'd0;
    #1;
    check("lock_hold_ready", 32'(in_ready), 32'b0010);
    step();
    check("lock_b2_ch", 32'(out_ch), 32'd1);
    check("lock_b2_last", 32'(out_last), 32'd0);
    in_last = 4'b0010;
    step();
    check("lock_b3_ch", 32'(out_ch), 32'd1);
    check("lock_b3_last", 32'(out_last), 32'd1);
    in_last = 4'b0000;
    step();
    check("lock_after_ch", 32'(out_ch), 32'd0);
    check("lock_after_last", 32'(out_last), 32'd0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
